// File: rtl/xnor_prbs_checker.sv
// xnor_prbs_checker: self-synchronising XNOR-LFSR PRBS checker (ports: clk, rst_n, din, din_valid, clr_cnt -> locked, err_pulse, err_count)
module xnor_prbs_checker #(
  parameter int WIDTH      = 7,
  parameter int TAP_A      = 7,
  parameter int TAP_B      = 6,
  parameter int LOCK_CNT   = 16,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [FW-1:0] fill, fill_nx;
  logic [MW-1:0] match, match_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [EW-1:0] werr, werr_nx;
  logic pred, err, lose;
  assign pred   = ~(sr[TAP_A-1] ^ sr[TAP_B-1]);
  assign err    = din_valid && state == LOCKED && din != pred;
  assign lose   = err && werr == EW'(ERR_THRESH - 1);
  assign locked = state == LOCKED;
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    fill_nx  = fill;
    match_nx = match;
    wcnt_nx  = wcnt;
    werr_nx  = werr;
    if (din_valid && state == HUNT) begin
      sr_nx = {sr[WIDTH-2:0], din};
      if (fill != FW'(WIDTH)) fill_nx = fill + 1'b1;
      else if (din == pred && !(&sr)) begin
        match_nx = match + 1'b1;
        state_nx = match == MW'(LOCK_CNT - 1) ? LOCKED : HUNT;
      end else match_nx = '0;
    end else if (din_valid) begin
      // once locked the local generator free-runs on its own prediction
      sr_nx    = {sr[WIDTH-2:0], pred};
      state_nx = lose ? HUNT : LOCKED;
      fill_nx  = lose ? '0 : fill;
      match_nx = lose ? '0 : match;
      wcnt_nx  = (lose || wcnt == WW'(WINDOW - 1)) ? '0 : wcnt + 1'b1;
      werr_nx  = (lose || wcnt == WW'(WINDOW - 1)) ? '0 : werr + EW'(err);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      fill      <= '0;
      match     <= '0;
      wcnt      <= '0;
      werr      <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      fill      <= fill_nx;
      match     <= match_nx;
      wcnt      <= wcnt_nx;
      werr      <= werr_nx;
      err_pulse <= err;
      err_count <= clr_cnt ? '0 : (err && !(&err_count)) ? err_count + 1'b1 : err_count;
    end
  end
endmodule

// File: tb/tb_xnor_prbs_checker.sv
// tb_xnor_prbs_checker: randomized and directed checks of xnor_prbs_checker against a behavioural model
module tb_xnor_prbs_checker;
  logic clk = 0, rst_n = 0, din = 0, din_valid = 0, clr_cnt = 0;
  logic locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0] err_count4;
  int n_cmp = 0, n_bad = 0, pulses = 0;
  logic [6:0] g = '0;
  bit hist[$];
  bit m_lock, m_pulse;
  int m_fill, m_match, m_wpos, m_werr, m_cnt, m_cnt4;
  always #5 clk = ~clk;
  xnor_prbs_checker dut (.clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
                         .locked(locked), .err_pulse(err_pulse), .err_count(err_count));
  xnor_prbs_checker #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
                         .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic bit gen_bit();
    bit b;
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
    return b;
  endfunction
  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < 7; i++) hist.push_back(1'b0);
    m_lock = 0; m_pulse = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_cnt = 0; m_cnt4 = 0;
  endfunction
  function automatic void model_update(input bit v, input bit d, input bit c);
    bit p, e, ones;
    e = 0;
    m_pulse = 0;
    if (v) begin
      p = !(hist[6] ^ hist[5]);
      ones = 1;
      foreach (hist[i]) ones &= hist[i];
      if (!m_lock) begin
        hist.push_front(d);
        if (m_fill < 7) m_fill++;
        else if (d == p && !ones) begin
          m_match++;
          if (m_match == 16) m_lock = 1;
        end else m_match = 0;
      end else begin
        e = d != p;
        hist.push_front(p);
        m_pulse = e;
        if (e) m_werr++;
        if (m_werr >= 8) begin
          m_lock = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
        end else if (m_wpos == 63) begin
          m_wpos = 0; m_werr = 0;
        end else m_wpos++;
      end
      void'(hist.pop_back());
    end
    if (c) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (e) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endfunction
  task automatic step(input bit v, input bit d, input bit c);
    din_valid = v; din = d; clr_cnt = c;
    @(posedge clk);
    model_update(v, d, c);
    #1;
    if (err_pulse === 1'b1) pulses++;
    check("locked", locked, m_lock);
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, m_cnt);
    check("locked4", locked4, m_lock);
    check("err_count4", err_count4, m_cnt4);
  endtask
  task automatic send(input bit flip, input bit c);
    bit b;
    b = gen_bit();
    step(1'b1, b ^ flip, c);
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_count", err_count, 0);
    #2 rst_n = 1;
  endtask
  initial begin
    int nv, seen;
    model_reset();
    #3;
    check("por_locked", locked, 0);
    check("por_count", err_count, 0);
    #5 rst_n = 1;
    for (int i = 1; i <= 500; i++) begin
      send(0, 0);
      if (i == 22) check("lock_bit22", locked, 0);
      if (i == 23) check("lock_bit23", locked, 1);
    end
    check("clean_count", err_count, 0);
    pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      send(i == 100, 0);
      if (i == 100) check("single_pulse_now", err_pulse, 1);
    end
    check("single_pulses", pulses, 1);
    check("single_count", err_count, 1);
    check("single_locked", locked, 1);
    for (int k = 0; k < 64 && m_wpos != 0; k++) send(0, 0);
    pulses = 0;
    for (int j = 0; j <= 21; j++) begin
      send(j % 3 == 0, 0);
      if (j == 18) check("loss_before8", locked, 1);
    end
    check("loss_locked", locked, 0);
    check("loss_pulses", pulses, 8);
    check("loss_count", err_count, 9);
    for (int i = 1; i <= 23; i++) begin
      send(0, 0);
      if (i == 22) check("relock_bit22", locked, 0);
    end
    check("relock_bit23", locked, 1);
    check("relock_count", err_count, 9);
    do_reset();
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1, 1, 0);
      if (locked !== 1'b0) seen++;
    end
    check("lockup_never", seen, 0);
    do_reset();
    nv = 0;
    for (int i = 0; i < 400 && !locked; i++) begin
      bit v;
      v = $urandom_range(0, 1);
      if (v) begin
        nv++;
        send(0, 0);
      end else step(0, 1'($urandom), 0);
    end
    check("stall_locked", locked, 1);
    check("stall_bits", nv, 23);
    send(0, 0);
    send(1, 1);
    check("clr_pulse", err_pulse, 1);
    check("clr_count", err_count, 0);
    for (int i = 1; i <= 200; i++) send(i % 10 == 0, 0);
    check("sat_count4", err_count4, 15);
    check("sat_count", err_count, 20);
    check("sat_locked", locked, 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) send($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      else step(0, 1'($urandom), $urandom_range(0, 99) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
